// File: rtl/mux2_select_pkg.sv
// rtl/mux2_select_pkg.sv - shared constants for the 2:1 selector array and shifter stages
//
// Purpose:
//    Holds the values that the selector and the barrel-shifter stages built on
//    top of it agree on: the default lane width, the value the optional output
//    register returns to while reset is active, and a small sizing helper.
//
// Contents:
//    DEFAULT_WIDTH  default bits per lane.
//    OUT_RESET_VAL  bit value replicated across the registered output during reset.
//    total_bits()   packed width of a LANES x WIDTH bus.

package mux2_select_pkg;

   localparam int DEFAULT_WIDTH = 1;

   localparam bit OUT_RESET_VAL = 1'b0;

   function automatic int total_bits(input int width, input int lanes);
      return width * lanes;
   endfunction

endpackage

// File: rtl/mux2_select_if.sv
// rtl/mux2_select_if.sv - bundled data and valid signals of one selector array
//
// Purpose:
//    Groups the per-lane sources, selects and the qualifying valid flags of a
//    mux2_select instance so a producer and a consumer can share one handle.
//
// Signals:
//    in0, in1   LANES*WIDTH  sources; lane k at [k*WIDTH +: WIDTH].
//    sel        LANES        per-lane select.
//    in_valid   1            qualifies in0/in1/sel.
//    out        LANES*WIDTH  selected data.
//    out_valid  1            qualifies out.
//
// Modports:
//    master  drives the sources, observes the result.
//    slave   the selector side: takes the sources, drives the result.

interface mux2_select_if
   import mux2_select_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int LANES = 1
);

   logic [LANES*WIDTH-1:0] in0;
   logic [LANES*WIDTH-1:0] in1;
   logic [LANES-1:0]       sel;
   logic                   in_valid;
   logic [LANES*WIDTH-1:0] out;
   logic                   out_valid;

   modport master (
      output in0,
      output in1,
      output sel,
      output in_valid,
      input  out,
      input  out_valid
   );

   modport slave (
      input  in0,
      input  in1,
      input  sel,
      input  in_valid,
      output out,
      output out_valid
   );

endinterface

// File: rtl/mux2_select_lane.sv
// rtl/mux2_select_lane.sv - one WIDTH-bit combinational 2:1 mux lane
//
// Purpose:
//    Single lane of the selector array. Picks in1 when sel is high, in0
//    otherwise. The conditional operator is used deliberately so an unknown
//    select still yields the agreeing source bits and X only where they differ.
//
// Ports:
//    in0  input   WIDTH  source for sel = 0.
//    in1  input   WIDTH  source for sel = 1.
//    sel  input   1      lane select.
//    out  output  WIDTH  selected data.

module mux2_lane
   import mux2_select_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             sel,
   output logic [WIDTH-1:0] out
);

   assign out = sel ? in1 : in0;

endmodule

// File: rtl/mux2_select.sv
// rtl/mux2_select.sv - parameterized array of independent 2:1 selector lanes
//
// Purpose:
//    LANES independent WIDTH-bit 2:1 muxes, each steered by its own select bit.
//    Used as the per-stage primitive of the ALU barrel shifters, where each
//    stage picks the unshifted or the shifted source. With OUT_REG=1 a single
//    register stage (data and valid) is inserted for timing-closed datapaths.
//
// Parameters:
//    WIDTH    bits per lane (>= 1).
//    LANES    number of lanes (>= 1).
//    OUT_REG  0 = combinational, 1 = registered with 1-cycle latency.
//
// Ports (order kept so legacy 4-port positional hookups in0,in1,sel,out work):
//    in0        input   LANES*WIDTH  source for sel[k] = 0, lane k at [k*WIDTH +: WIDTH].
//    in1        input   LANES*WIDTH  source for sel[k] = 1, same packing.
//    sel        input   LANES        per-lane select.
//    out        output  LANES*WIDTH  selected data, same packing.
//    CLK        input   1            rising-edge clock, used only when OUT_REG=1.
//    RESET      input   1            asynchronous active-high reset, used only when OUT_REG=1.
//    in_valid   input   1            qualifies the inputs.
//    out_valid  output  1            qualifies out.

module mux2_select
   import mux2_select_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int LANES   = 1,
   parameter int OUT_REG = 0
) (
   input  logic [LANES*WIDTH-1:0] in0,
   input  logic [LANES*WIDTH-1:0] in1,
   input  logic [LANES-1:0]       sel,
   output logic [LANES*WIDTH-1:0] out,
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   in_valid,
   output logic                   out_valid
);

   localparam int NBITS = total_bits(WIDTH, LANES);

   // A zero-sized lane or array has no meaningful packing; stop elaboration.
   if (WIDTH < 1) begin : g_bad_width
      $error("mux2_select: WIDTH must be at least 1");
   end
   if (LANES < 1) begin : g_bad_lanes
      $error("mux2_select: LANES must be at least 1");
   end

   logic [NBITS-1:0] mux_out;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      mux2_lane #(
         .WIDTH (WIDTH)
      ) u_lane (
         .in0 (in0[k*WIDTH +: WIDTH]),
         .in1 (in1[k*WIDTH +: WIDTH]),
         .sel (sel[k]),
         .out (mux_out[k*WIDTH +: WIDTH])
      );
   end

   if (OUT_REG != 0) begin : g_reg
      logic [NBITS-1:0] out_q;
      logic             valid_q;

      // Loads every cycle with no enable; reset wins over the clock so a
      // sample in flight when reset arrives is dropped.
      always_ff @(posedge CLK or posedge RESET) begin
         if (RESET) begin
            out_q   <= {NBITS{OUT_RESET_VAL}};
            valid_q <= 1'b0;
         end else begin
            out_q   <= mux_out;
            valid_q <= in_valid;
         end
      end

      assign out       = out_q;
      assign out_valid = valid_q;
   end else begin : g_comb
      // Clock and reset have no function in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = CLK ^ RESET;

      assign out       = mux_out;
      assign out_valid = in_valid;
   end

endmodule

// File: tb/tb_mux2_select.sv
// tb/tb_mux2_select.sv - self-checking bench for mux2_select
module tb_mux2_select;

   int checks;
   int failures;

   logic clk;
   logic rst_unused;
   logic rst_r;
   logic rst_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Default build: single-bit combinational mux.
   mux2_select_if #(.WIDTH(1), .LANES(1)) if_d ();
   // WIDTH=8, one lane, combinational.
   mux2_select_if #(.WIDTH(8), .LANES(1)) if_w ();
   // Eight 1-bit lanes, one shifter stage.
   mux2_select_if #(.WIDTH(1), .LANES(8)) if_l ();
   // WIDTH=8 registered.
   mux2_select_if #(.WIDTH(8), .LANES(1)) if_r ();
   // 4x4 combinational and registered, random stimulus.
   mux2_select_if #(.WIDTH(4), .LANES(4)) if_c ();
   mux2_select_if #(.WIDTH(4), .LANES(4)) if_q ();

   mux2_select u_d (
      .in0 (if_d.in0), .in1 (if_d.in1), .sel (if_d.sel), .out (if_d.out),
      .CLK (clk), .RESET (rst_unused), .in_valid (if_d.in_valid), .out_valid (if_d.out_valid)
   );

   mux2_select #(.WIDTH(8), .LANES(1), .OUT_REG(0)) u_w (
      .in0 (if_w.in0), .in1 (if_w.in1), .sel (if_w.sel), .out (if_w.out),
      .CLK (clk), .RESET (rst_unused), .in_valid (if_w.in_valid), .out_valid (if_w.out_valid)
   );

   mux2_select #(.WIDTH(1), .LANES(8), .OUT_REG(0)) u_l (
      .in0 (if_l.in0), .in1 (if_l.in1), .sel (if_l.sel), .out (if_l.out),
      .CLK (clk), .RESET (rst_unused), .in_valid (if_l.in_valid), .out_valid (if_l.out_valid)
   );

   mux2_select #(.WIDTH(8), .LANES(1), .OUT_REG(1)) u_r (
      .in0 (if_r.in0), .in1 (if_r.in1), .sel (if_r.sel), .out (if_r.out),
      .CLK (clk), .RESET (rst_r), .in_valid (if_r.in_valid), .out_valid (if_r.out_valid)
   );

   mux2_select #(.WIDTH(4), .LANES(4), .OUT_REG(0)) u_c (
      .in0 (if_c.in0), .in1 (if_c.in1), .sel (if_c.sel), .out (if_c.out),
      .CLK (clk), .RESET (rst_unused), .in_valid (if_c.in_valid), .out_valid (if_c.out_valid)
   );

   mux2_select #(.WIDTH(4), .LANES(4), .OUT_REG(1)) u_q (
      .in0 (if_q.in0), .in1 (if_q.in1), .sel (if_q.sel), .out (if_q.out),
      .CLK (clk), .RESET (rst_q), .in_valid (if_q.in_valid), .out_valid (if_q.out_valid)
   );

   typedef struct {
      logic [7:0]  in0;
      logic [7:0]  in1;
      logic [7:0]  sel;
      logic        iv;
      logic [7:0]  exp;
      int unsigned dut;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference: build a bit mask from the lane selects by arithmetic
   // (each selected lane contributes 0xF shifted to its position) and blend.
   function automatic logic [15:0] ref_sel(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] s);
      int unsigned m;
      m = 0;
      for (int k = 0; k < 4; k++)
         if (s[k]) m = m + (15 << (4 * k));
      return (b & 16'(m)) | (a & ~16'(m));
   endfunction

   initial begin
      logic [7:0]  truth;
      logic [15:0] a, b, e;
      logic [3:0]  s;
      logic        iv, r;

      checks     = 0;
      failures   = 0;
      rst_unused = 1'b0;
      rst_r      = 1'b1;
      rst_q      = 1'b1;
      {if_d.in0, if_d.in1, if_d.sel, if_d.in_valid} = '0;
      {if_w.in0, if_w.in1, if_w.sel, if_w.in_valid} = '0;
      {if_l.in0, if_l.in1, if_l.sel, if_l.in_valid} = '0;
      {if_r.in0, if_r.in1, if_r.sel, if_r.in_valid} = '0;
      {if_c.in0, if_c.in1, if_c.sel, if_c.in_valid} = '0;
      {if_q.in0, if_q.in1, if_q.sel, if_q.in_valid} = '0;

      // Truth column indexed by {in0,in1,sel}.
      truth = 8'hD8;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] idx;
         idx = 3'(i);
         vecs.push_back('{in0: {7'b0, idx[2]}, in1: {7'b0, idx[1]}, sel: {7'b0, idx[0]},
                          iv: idx[1] ^ idx[2], exp: {7'b0, truth[i]}, dut: 0});
      end
      vecs.push_back('{in0: 8'hA5, in1: 8'h3C, sel: 8'h00, iv: 1'b1, exp: 8'hA5, dut: 1});
      vecs.push_back('{in0: 8'hA5, in1: 8'h3C, sel: 8'h01, iv: 1'b0, exp: 8'h3C, dut: 1});
      vecs.push_back('{in0: 8'h96, in1: 8'hCB, sel: 8'hFF, iv: 1'b1, exp: 8'hCB, dut: 2});
      vecs.push_back('{in0: 8'h96, in1: 8'hCB, sel: 8'h00, iv: 1'b0, exp: 8'h96, dut: 2});
      vecs.push_back('{in0: 8'h96, in1: 8'hCB, sel: 8'h0F, iv: 1'b1, exp: 8'h9B, dut: 2});

      // Registered build is in reset from time zero.
      #1;
      check("reg_reset_out", 32'(if_r.out), 32'h0);
      check("reg_reset_valid", 32'(if_r.out_valid), 32'h0);

      // Table-driven combinational vectors.
      foreach (vecs[i]) begin
         case (vecs[i].dut)
            0: begin
               if_d.in0 = vecs[i].in0[0];
               if_d.in1 = vecs[i].in1[0];
               if_d.sel = vecs[i].sel[0];
               if_d.in_valid = vecs[i].iv;
               #1;
               check($sformatf("dflt_out_%0d", i), 32'(if_d.out), 32'(vecs[i].exp[0]));
               check($sformatf("dflt_valid_%0d", i), 32'(if_d.out_valid), 32'(vecs[i].iv));
            end
            1: begin
               if_w.in0 = vecs[i].in0;
               if_w.in1 = vecs[i].in1;
               if_w.sel = vecs[i].sel[0];
               if_w.in_valid = vecs[i].iv;
               #1;
               check($sformatf("w8_out_%0d", i), 32'(if_w.out), 32'(vecs[i].exp));
               check($sformatf("w8_valid_%0d", i), 32'(if_w.out_valid), 32'(vecs[i].iv));
            end
            default: begin
               if_l.in0 = vecs[i].in0;
               if_l.in1 = vecs[i].in1;
               if_l.sel = vecs[i].sel;
               if_l.in_valid = vecs[i].iv;
               #1;
               check($sformatf("l8_out_%0d", i), 32'(if_l.out), 32'(vecs[i].exp));
               check($sformatf("l8_valid_%0d", i), 32'(if_l.out_valid), 32'(vecs[i].iv));
            end
         endcase
      end

      // Unknown select: agreeing source bits must come through.
      if_w.in0 = 8'h5A;
      if_w.in1 = 8'h5A;
      if_w.sel = 1'bx;
      #1;
      check("selx_equal", 32'(if_w.out), 32'h5A);
      if_w.in0 = 8'hF0;
      if_w.in1 = 8'hFF;
      #1;
      check("selx_agree_bits", 32'(if_w.out & 8'hF0), 32'hF0);
      if_w.sel = 1'b0;

      // Reset held across an edge does not load.
      @(posedge clk);
      #1;
      check("reg_reset_hold", 32'(if_r.out), 32'h0);

      // 1-cycle latency.
      @(negedge clk);
      rst_r = 1'b0;
      if_r.in0 = 8'h11;
      if_r.in1 = 8'h22;
      if_r.sel = 1'b1;
      if_r.in_valid = 1'b1;
      #3;
      check("reg_before_edge", 32'(if_r.out), 32'h0);
      check("reg_before_edge_valid", 32'(if_r.out_valid), 32'h0);
      @(posedge clk);
      #1;
      check("reg_after_edge", 32'(if_r.out), 32'h22);
      check("reg_after_edge_valid", 32'(if_r.out_valid), 32'h1);

      // Async reset between edges clears immediately.
      #2;
      rst_r = 1'b1;
      #1;
      check("async_rst_out", 32'(if_r.out), 32'h0);
      check("async_rst_valid", 32'(if_r.out_valid), 32'h0);
      for (int n = 0; n < 2; n++) begin
         @(posedge clk);
         #1;
         check($sformatf("rst_hold_out_%0d", n), 32'(if_r.out), 32'h0);
         check($sformatf("rst_hold_valid_%0d", n), 32'(if_r.out_valid), 32'h0);
      end
      @(negedge clk);
      rst_r = 1'b0;
      if_r.in0 = 8'h33;
      if_r.in1 = 8'h44;
      if_r.sel = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_load", 32'(if_r.out), 32'h33);
      check("post_rst_valid", 32'(if_r.out_valid), 32'h1);

      // Loads regardless of in_valid.
      @(negedge clk);
      if_r.in0 = 8'h55;
      if_r.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("load_no_valid", 32'(if_r.out), 32'h55);
      check("load_no_valid_v", 32'(if_r.out_valid), 32'h0);

      // Random stimulus on 4x4 builds, with occasional reset pulses.
      for (int n = 0; n < 150; n++) begin
         @(negedge clk);
         r  = ($urandom_range(15) == 0);
         a  = 16'($urandom);
         b  = 16'($urandom);
         s  = 4'($urandom);
         iv = 1'($urandom);
         rst_q = r;
         if_c.in0 = a; if_c.in1 = b; if_c.sel = s; if_c.in_valid = iv;
         if_q.in0 = a; if_q.in1 = b; if_q.sel = s; if_q.in_valid = iv;
         e = ref_sel(a, b, s);
         #1;
         check($sformatf("rnd_comb_%0d", n), 32'(if_c.out), 32'(e));
         check($sformatf("rnd_comb_v_%0d", n), 32'(if_c.out_valid), 32'(iv));
         if (r) begin
            check($sformatf("rnd_async_%0d", n), 32'({if_q.out_valid, if_q.out}), 32'h0);
         end
         @(posedge clk);
         #1;
         check($sformatf("rnd_reg_%0d", n), 32'(if_q.out), r ? 32'h0 : 32'(e));
         check($sformatf("rnd_reg_v_%0d", n), 32'(if_q.out_valid), r ? 32'h0 : 32'(iv));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux2_select.md
Name: mux2_select

Overview:
- Parameterized 2:1 selector array: LANES independent lanes, each WIDTH bits, each with its own select bit.
- Primitive used by the ALU barrel shifters (sra/srl/sll/ror stages), where each stage bit picks "unshifted" vs "shifted" source.
- Default configuration (LANES=1, WIDTH=1, OUT_REG=0) is a purely combinational single-bit 2:1 mux.
- The OUT_REG=1 option inserts one pipeline register per lane for timing-closed datapaths.

Parameters:
- WIDTH, 1, bits per lane.
- LANES, 1, number of independent 2:1 lanes.
- OUT_REG, 0, 0 = combinational output; 1 = registered output with 1-cycle latency.

Ports:
- CLK  input  1  rising-edge clock; used only when OUT_REG=1.
- RESET  input  1  asynchronous, active-high reset; used only when OUT_REG=1.
- in0  input  LANES*WIDTH  source selected when the lane's select bit is 0; lane k occupies bits [k*WIDTH +: WIDTH].
- in1  input  LANES*WIDTH  source selected when the lane's select bit is 1; same packing as in0.
- sel  input  LANES  per-lane select; sel[k] controls lane k.
- in_valid  input  1  qualifies in0/in1/sel; pipelined alongside data when OUT_REG=1.
- out  output  LANES*WIDTH  selected data, same packing as in0.
- out_valid  output  1  qualifies out.

Behaviour:
- Per lane k:
  - sel[k]=0 → out lane k = in0 lane k.
  - sel[k]=1 → out lane k = in1 lane k.
- Lanes are fully independent; no cross-lane interaction.
- Port order in positional instantiation is fixed: in0, in1, sel, out. CLK, RESET, in_valid and out_valid are appended after out, so legacy 4-port positional hookups stay valid.
- X/Z on sel[k]:
  - If in0 and in1 lane bits are equal, output that value.
  - Otherwise output X (standard conditional-operator semantics).
- No tri-state.
- OUT_REG=0:
  - out and out_valid are pure combinational functions of the inputs, with zero-cycle latency.
  - out_valid = in_valid.
  - CLK and RESET are ignored; no state.
- OUT_REG=1:
  - Latency is exactly 1 cycle: values sampled on CLK rising edge N appear on out after edge N.
  - The register loads every cycle regardless of in_valid (no enable/stall).
  - out_valid is the registered in_valid.
  - No backpressure or handshake; the consumer must accept every cycle.
- Reset (OUT_REG=1):
  - RESET high asynchronously forces out to 0 and out_valid to 0, immediately and without waiting for CLK.
  - While RESET is high, rising CLK edges do not load.
  - After RESET deasserts, the first rising edge loads normally.
  - Reset asserted mid-stream discards the in-flight sample.
- No functional delay annotations inside the block. Shifter-level output delays (#2) are applied by the instantiating module, not here.
- Width rules: no arithmetic; pure bit routing.
  - WIDTH ≥ 1 and LANES ≥ 1 are required.
  - Elaboration fails on 0, via a generate-time check.

Decomposition:
- Shared package (processor-wide): no typedefs needed. Define localparam DEFAULT_WIDTH=1 and the reset value OUT_RESET_VAL='0 for reuse by shifter modules.
- One natural sub-module: mux2_lane. It is a single WIDTH-bit combinational 2:1 mux (in0, in1, sel, out).
- mux2_select generates LANES instances of mux2_lane, plus the optional output register stage under OUT_REG.

Test Plan:
- Default config, exhaustive (in0, in1, sel) over all 8 combinations. Required: out = sel ? in1 : in0, e.g. in0=1, in1=0, sel=0 → out=1; sel=1 → out=0.
- WIDTH=8, LANES=1: in0=8'hA5, in1=8'h3C. sel=0 → out=8'hA5; sel=1 → out=8'h3C; out_valid follows in_valid combinationally.
- LANES=8, WIDTH=1, modelling a shifter stage:
  - in0=data=8'b1001_0110.
  - in1={data[7], data[7:1]}=8'b1100_1011.
  - sel=8'hFF → out=8'hCB; sel=8'h00 → out=8'h96; sel=8'h0F → out=8'h9B.
- OUT_REG=1, WIDTH=8:
  - in0=8'h11, in1=8'h22, sel=1, in_valid=1 applied before edge N.
  - out=8'h22 and out_valid=1 only after edge N; out is still at its prior value just before edge N.
- OUT_REG=1, async reset:
  - With out=8'h22, assert RESET between edges. out=8'h00 and out_valid=0 immediately.
  - Hold RESET across 2 edges with in_valid=1 → outputs stay 0.
  - Deassert; the next edge loads the current inputs.
- sel=X with in0=in1=8'h5A → out=8'h5A. sel=X with in0≠in1 → out bits that differ are X.
